riscv_clint: RTL and testbench
==============================

Name: riscv_clint

Overview:
- Core-local interruptor on router port1 (0x0200_0000–0x0200_FFFF), the data-bus stage directly downstream of the router.
- Holds the msip, mtimecmp and mtime registers.
- Generates machine timer and software interrupt lines to the CSR/trap unit.
- Single-beat, full 64-bit accesses only: port1 carries no byte mask.

Parameters:
- DBUS_DATA_WIDTH, 64, data bus width; must be 64.
- DMEM_ADDR_WIDTH, 64, address width.
- TICK_DIV, 1, core clock cycles per mtime increment; legal range ≥1.

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_wr_en  input  1  write strobe from router o_port1_wr_en
- i_rd_en  input  1  read strobe from router o_port1_rd_en
- i_addr  input  DMEM_ADDR_WIDTH  access address from router o_port1_addr
- i_wdata  input  DBUS_DATA_WIDTH  write data
- o_rdata  output  DBUS_DATA_WIDTH  read data, to router i_port1_rdata
- o_rdata_valid  output  1  read data valid, to router i_port1_rdata_valid
- o_wr_ready  output  1  write accepted, to router i_port1_wr_ready
- o_timer_irq  output  1  machine timer interrupt (MTIP)
- o_soft_irq  output  1  machine software interrupt (MSIP)

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - o_rdata=0, o_rdata_valid=0, o_wr_ready=0, o_timer_irq=0, o_soft_irq=0.
- Address decode uses i_addr[15:0] only; upper bits are already decoded by the router.
  - 16'h0000: msip; bit0 is RW, other bits read 0.
  - 16'h4000: mtimecmp, 64-bit RW.
  - 16'hBFF8: mtime, 64-bit RW.
  - Any other offset: reads return 0, writes are dropped. The handshake still completes; no error is signalled.
- Read:
  - i_rd_en sampled high at edge N → o_rdata = register value at edge N, and o_rdata_valid=1 for exactly one cycle after edge N.
  - o_rdata_valid is a pulse, not a level. A strobe held high for k cycles gives k consecutive pulses.
  - o_rdata holds its last value when valid is low.
- Write:
  - i_wr_en sampled high at edge N → register updated at edge N, and o_wr_ready=1 for one cycle after edge N.
  - A read in that following cycle returns the new value.
- Simultaneous i_rd_en and i_wr_en, same address: the write is performed, and the read returns the pre-write value. Both valid and ready pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick on wrap.
  - With TICK_DIV=1, mtime increments every cycle.
  - mtime += 1 on each tick, wrapping 2^64-1 → 0 with no flag.
- A write to mtime in a tick cycle wins over the increment. The prescaler is not reset by mtime writes.
- o_timer_irq is registered: (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the post-update register values. It asserts one cycle after the condition becomes true, and clears one cycle after a mtimecmp/mtime write makes it false.
- o_soft_irq is the registered msip bit0.
- No backpressure: every strobe is accepted in the cycle it is sampled.

Decomposition:
- Shared package/defines (top_defines.v):
  - CLINT_MSIP_OFS=16'h0000, CLINT_MTIMECMP_OFS=16'h4000, CLINT_MTIME_OFS=16'hBFF8.
  - CLINT_BASE=64'h0000_0000_0200_0000.
  - MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF.
- One natural sub-module: riscv_clint_tick. It contains the prescaler counter and produces a one-cycle tick pulse; parameterised by TICK_DIV; same clock and reset.

Test Plan:
- Reset, then read 0x0200_BFF8 after 10 cycles with TICK_DIV=1 → o_rdata_valid pulse one cycle later. o_rdata equals 10 ± the sample alignment, checked exactly against the bench model. mtimecmp reads 64'hFFFF_FFFF_FFFF_FFFF; o_timer_irq=0.
- Write mtimecmp=64'd50 with mtime counting from 0 → o_wr_ready pulses once. o_timer_irq rises in the cycle after mtime reaches 50. Then write mtimecmp=64'd1000 → o_timer_irq falls one cycle after o_wr_ready.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 → after 2 ticks mtime reads 0 (wrap). With mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, o_timer_irq is high for exactly the cycle after mtime=all-ones.
- Write 0x0200_0000 with wdata=64'h3 → o_soft_irq=1 next cycle; readback is 64'h1. Write 0 → o_soft_irq=0.
- TICK_DIV=4: write mtime=100 in a tick cycle → mtime reads 100, not 101. Next increment is 4 cycles after the prior tick.
- Read/write offset 16'h1234 → o_rdata=0 with valid pulse, and ready pulse. No register changes. Assert i_rst_n=0 mid-access → all outputs 0 immediately (asynchronous), with no valid or ready pulse after release.

Source files
------------

// File: rtl/riscv_clint_pkg.sv
`default_nettype none
// ==========================================================================
// riscv_clint_pkg : CLINT register map, reset values and offset decoder
// Rev 1.0
// ==========================================================================
package riscv_clint_pkg;

   localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;
   localparam logic [63:0] CLINT_BASE         = 64'h0000_0000_0200_0000;
   localparam logic [63:0] MTIMECMP_RST       = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      REG_NONE     = 2'd0,
      REG_MSIP     = 2'd1,
      REG_MTIMECMP = 2'd2,
      REG_MTIME    = 2'd3
   } clint_reg_e;

   function automatic clint_reg_e clint_decode(input logic [15:0] ofs);
      case (ofs)
         CLINT_MSIP_OFS:     return REG_MSIP;
         CLINT_MTIMECMP_OFS: return REG_MTIMECMP;
         CLINT_MTIME_OFS:    return REG_MTIME;
         default:            return REG_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_clint_if.sv
`default_nettype none
// ==========================================================================
// riscv_clint_if : router port1 single-beat data-bus link into the CLINT
// Rev 1.0
// ==========================================================================
interface riscv_clint_if #(
   parameter int DBUS_DATA_WIDTH = 64,
   parameter int DMEM_ADDR_WIDTH = 64
) ();

   logic                       wr_en;
   logic                       rd_en;
   logic [DMEM_ADDR_WIDTH-1:0] addr;
   logic [DBUS_DATA_WIDTH-1:0] wdata;
   logic [DBUS_DATA_WIDTH-1:0] rdata;
   logic                       rdata_valid;
   logic                       wr_ready;

   modport master (
      output wr_en, rd_en, addr, wdata,
      input  rdata, rdata_valid, wr_ready
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata,
      output rdata, rdata_valid, wr_ready
   );

endinterface
`default_nettype wire

// File: rtl/riscv_clint_tick.sv
`default_nettype none
// ==========================================================================
// riscv_clint_tick : mtime prescaler, one-cycle tick every TICK_DIV clocks
// Rev 1.0
// ==========================================================================
module riscv_clint_tick #(
   parameter int TICK_DIV = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With TICK_DIV=1 the counter is pinned at 0 and every cycle is a tick.
   always_comb begin
      o_tick = (cnt_q == CNT_LAST);
      cnt_d  = o_tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/riscv_clint.sv
`default_nettype none
// ==========================================================================
// riscv_clint : core-local interruptor (msip / mtimecmp / mtime) on port1
// Rev 1.0
// ==========================================================================
module riscv_clint
   import riscv_clint_pkg::*;
#(
   parameter int DBUS_DATA_WIDTH = 64,
   parameter int DMEM_ADDR_WIDTH = 64,
   parameter int TICK_DIV        = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   riscv_clint_if.slave  bus,
   output logic          o_timer_irq,
   output logic          o_soft_irq
);

   logic                       tick;
   clint_reg_e                 sel;
   logic                       unused_addr_hi;

   logic [63:0]                mtime_q, mtime_d;
   logic [63:0]                mtimecmp_q, mtimecmp_d;
   logic                       msip_q, msip_d;
   logic                       timer_irq_q, timer_irq_d;
   logic [DBUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                       rdata_valid_q, rdata_valid_d;
   logic                       wr_ready_q, wr_ready_d;
   logic [DBUS_DATA_WIDTH-1:0] rd_mux;

   riscv_clint_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_tick  (tick)
   );

   // The router has already matched the upper address bits.
   assign sel            = clint_decode(bus.addr[15:0]);
   assign unused_addr_hi = ^bus.addr[DMEM_ADDR_WIDTH-1:16];

   always_comb begin
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (bus.wr_en) begin
         case (sel)
            REG_MSIP:     msip_d     = bus.wdata[0];
            REG_MTIMECMP: mtimecmp_d = bus.wdata;
            REG_MTIME:    mtime_d    = bus.wdata;
            default:      ;
         endcase
      end
   end

   // Reads see the pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      case (sel)
         REG_MSIP:     rd_mux = {{(DBUS_DATA_WIDTH-1){1'b0}}, msip_q};
         REG_MTIMECMP: rd_mux = mtimecmp_q;
         REG_MTIME:    rd_mux = mtime_q;
         default:      rd_mux = '0;
      endcase
      rdata_d       = bus.rd_en ? rd_mux : rdata_q;
      rdata_valid_d = bus.rd_en;
      wr_ready_d    = bus.wr_en;
      timer_irq_d   = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mtime_q       <= '0;
         mtimecmp_q    <= MTIMECMP_RST;
         msip_q        <= 1'b0;
         timer_irq_q   <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         wr_ready_q    <= 1'b0;
      end else begin
         mtime_q       <= mtime_d;
         mtimecmp_q    <= mtimecmp_d;
         msip_q        <= msip_d;
         timer_irq_q   <= timer_irq_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         wr_ready_q    <= wr_ready_d;
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.wr_ready    = wr_ready_q;
   assign o_timer_irq     = timer_irq_q;
   assign o_soft_irq      = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_clint.sv
`default_nettype none
// ==========================================================================
// tb_riscv_clint : self-checking bench for riscv_clint (TICK_DIV 1 and 4)
// Rev 1.0
// ==========================================================================
module tb_riscv_clint;
   import riscv_clint_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscv_clint_if #(.DBUS_DATA_WIDTH(64), .DMEM_ADDR_WIDTH(64)) bus0 ();
   riscv_clint_if #(.DBUS_DATA_WIDTH(64), .DMEM_ADDR_WIDTH(64)) bus1 ();
   logic timer0, soft0, timer1, soft1;

   riscv_clint #(.DBUS_DATA_WIDTH(64), .DMEM_ADDR_WIDTH(64), .TICK_DIV(1)) dut0 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus0.slave),
      .o_timer_irq (timer0),
      .o_soft_irq  (soft0)
   );

   riscv_clint #(.DBUS_DATA_WIDTH(64), .DMEM_ADDR_WIDTH(64), .TICK_DIV(4)) dut1 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus1.slave),
      .o_timer_irq (timer1),
      .o_soft_irq  (soft1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Reference model of dut0 registers, driven from the same bus inputs.
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_irq;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mtime <= 64'd0;
         m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
         m_msip  <= 1'b0;
         m_irq   <= 1'b0;
      end else begin
         m_irq <= (m_mtime >= m_cmp);
         if (bus0.wr_en && bus0.addr[15:0] == 16'hBFF8) m_mtime <= bus0.wdata;
         else                                           m_mtime <= m_mtime + 64'd1;
         if (bus0.wr_en && bus0.addr[15:0] == 16'h4000) m_cmp  <= bus0.wdata;
         if (bus0.wr_en && bus0.addr[15:0] == 16'h0000) m_msip <= bus0.wdata[0];
      end
   end

   function automatic logic [63:0] model_read(input logic [15:0] ofs);
      case (ofs)
         16'h0000: return {63'd0, m_msip};
         16'h4000: return m_cmp;
         16'hBFF8: return m_mtime;
         default:  return 64'd0;
      endcase
   endfunction

   int cyc1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc1 <= 0;
      else        cyc1 <= cyc1 + 1;
   end

   // Scoreboard: expected read data queued at issue, popped on rdata_valid.
   logic [63:0] exp_q[$];
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.rdata_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_valid: rdata_valid=1 with no read outstanding, rdata=%h", bus0.rdata);
            end else begin
               check("rdata", bus0.rdata, exp_q.pop_front());
            end
         end
         check("timer_irq", timer0, m_irq);
         check("soft_irq", soft0, m_msip);
      end
   end

   // Called just after a negedge; returns at the negedge after the sampling edge.
   task automatic bus_cycle(input logic wr, input logic rd, input logic [15:0] ofs,
                            input logic [63:0] wd, input logic use_const,
                            input logic [63:0] exp_rd);
      bus0.wr_en = wr;
      bus0.rd_en = rd;
      bus0.addr  = CLINT_BASE | 64'(ofs);
      bus0.wdata = wd;
      if (rd) exp_q.push_back(use_const ? exp_rd : model_read(ofs));
      @(negedge clk);
      check("wr_ready", bus0.wr_ready, 64'(wr));
      bus0.wr_en = 1'b0;
      bus0.rd_en = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] ofs;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_soft;
   } vec_t;

   localparam int NV = 18;
   vec_t        vecs [NV];
   logic [63:0] wrap_rd  [3];
   logic        wrap_irq [3];
   int          waited;

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 16'h4000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 16'h0000, 64'h0, 64'h0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 16'h0000, 64'h3, 64'h0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 16'h0000, 64'h0, 64'h1, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 16'h0000, 64'h0, 64'h1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 16'h0000, 64'h0, 64'h0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 16'h1234, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 16'h1234, 64'h5555_5555_5555_5555, 64'h0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 16'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 16'h4000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 16'h4008, 64'h5, 64'h0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 16'h4000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 16'h0000, 64'h0, 64'h0, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 16'h0000, 64'h1, 64'h0, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 16'h1234, 64'h0, 64'h0, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 16'h0000, 64'h0, 64'h0, 1'b0};
      wrap_rd[0]  = 64'hFFFF_FFFF_FFFF_FFFE; wrap_irq[0] = 1'b0;
      wrap_rd[1]  = 64'hFFFF_FFFF_FFFF_FFFF; wrap_irq[1] = 1'b1;
      wrap_rd[2]  = 64'h0;                   wrap_irq[2] = 1'b0;

      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.addr = '0; bus0.wdata = '0;
      bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.addr = '0; bus1.wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdata", bus0.rdata, 64'h0);
      check("rst_valid", bus0.rdata_valid, 64'h0);
      check("rst_ready", bus0.wr_ready, 64'h0);
      check("rst_timer", timer0, 64'h0);
      check("rst_soft", soft0, 64'h0);
      rst_n = 1'b1;

      // mtime after 10 ticks (read sampled at the 11th edge)
      repeat (10) @(negedge clk);
      bus_cycle(1'b0, 1'b1, CLINT_MTIME_OFS, 64'h0, 1'b1, 64'd10);
      // held strobe gives one pulse per cycle
      bus0.rd_en = 1'b1; bus0.addr = CLINT_BASE | 64'(CLINT_MTIME_OFS);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model_read(CLINT_MTIME_OFS));
         @(negedge clk);
      end
      bus0.rd_en = 1'b0;

      for (int i = 0; i < NV; i++) begin
         bus_cycle(vecs[i].wr, vecs[i].rd, vecs[i].ofs, vecs[i].wdata, 1'b1, vecs[i].exp_rdata);
         check($sformatf("vec%0d_soft", i), soft0, 64'(vecs[i].exp_soft));
      end

      // Timer compare rise and fall
      bus_cycle(1'b1, 1'b0, CLINT_MTIME_OFS, 64'd0, 1'b0, 64'h0);
      bus_cycle(1'b1, 1'b0, CLINT_MTIMECMP_OFS, 64'd50, 1'b0, 64'h0);
      waited = 0;
      while (!timer0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!timer0) begin
         n_checks++;
         $display("FAIL timer_rise_timeout: timer_irq=%b after %0d cycles, required 1", timer0, waited);
      end else begin
         bus_cycle(1'b0, 1'b1, CLINT_MTIME_OFS, 64'h0, 1'b1, 64'd51);
      end
      bus_cycle(1'b1, 1'b0, CLINT_MTIMECMP_OFS, 64'd1000, 1'b0, 64'h0);
      check("timer_still_high_with_ready", timer0, 64'h1);
      @(negedge clk);
      check("timer_fall", timer0, 64'h0);

      // mtime wrap with mtimecmp all-ones
      bus_cycle(1'b1, 1'b0, CLINT_MTIMECMP_OFS, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
      bus_cycle(1'b1, 1'b0, CLINT_MTIME_OFS, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0);
      check("wrap_timer_pre", timer0, 64'h0);
      bus0.rd_en = 1'b1; bus0.addr = CLINT_BASE | 64'(CLINT_MTIME_OFS);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(wrap_rd[i]);
         @(negedge clk);
         check($sformatf("wrap_timer%0d", i), timer0, 64'(wrap_irq[i]));
      end
      bus0.rd_en = 1'b0;

      // TICK_DIV=4 instance: free-run value, then write in a tick cycle
      bus1.rd_en = 1'b1; bus1.addr = CLINT_BASE | 64'(CLINT_MTIME_OFS);
      begin
         logic [63:0] exp_free;
         exp_free = 64'(cyc1 / 4);
         @(negedge clk);
         check("div4_free_valid", bus1.rdata_valid, 64'h1);
         check("div4_free_rdata", bus1.rdata, exp_free);
      end
      bus1.rd_en = 1'b0;
      while (((cyc1 + 1) % 4) != 0) @(negedge clk);
      bus1.wr_en = 1'b1; bus1.wdata = 64'd100;
      @(negedge clk);
      check("div4_wr_ready", bus1.wr_ready, 64'h1);
      bus1.wr_en = 1'b0; bus1.rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("div4_valid%0d", i), bus1.rdata_valid, 64'h1);
         check($sformatf("div4_rdata%0d", i), bus1.rdata, (i < 4) ? 64'd100 : 64'd101);
      end
      bus1.rd_en = 1'b0;

      // Asynchronous reset in the middle of an access
      bus_cycle(1'b1, 1'b0, CLINT_MSIP_OFS, 64'h1, 1'b0, 64'h0);
      bus_cycle(1'b1, 1'b0, CLINT_MTIMECMP_OFS, 64'h0, 1'b0, 64'h0);
      repeat (2) @(negedge clk);
      check("pre_rst_timer", timer0, 64'h1);
      check("pre_rst_soft", soft0, 64'h1);
      bus0.rd_en = 1'b1; bus0.wr_en = 1'b1;
      bus0.addr  = CLINT_BASE | 64'(CLINT_MTIME_OFS); bus0.wdata = 64'd7;
      exp_q.push_back(model_read(CLINT_MTIME_OFS));
      @(posedge clk);
      #1;
      check("pre_rst_valid", bus0.rdata_valid, 64'h1);
      check("pre_rst_ready", bus0.wr_ready, 64'h1);
      rst_n = 1'b0;
      #1;
      check("async_rdata", bus0.rdata, 64'h0);
      check("async_valid", bus0.rdata_valid, 64'h0);
      check("async_ready", bus0.wr_ready, 64'h0);
      check("async_timer", timer0, 64'h0);
      check("async_soft", soft0, 64'h0);
      check("async_rdata1", bus1.rdata, 64'h0);
      bus0.rd_en = 1'b0; bus0.wr_en = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_valid%0d", i), bus0.rdata_valid, 64'h0);
         check($sformatf("post_rst_ready%0d", i), bus0.wr_ready, 64'h0);
      end
      bus_cycle(1'b0, 1'b1, CLINT_MTIME_OFS, 64'h0, 1'b1, 64'd3);
      bus_cycle(1'b0, 1'b1, CLINT_MTIMECMP_OFS, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      bus_cycle(1'b0, 1'b1, CLINT_MSIP_OFS, 64'h0, 1'b1, 64'h0);

      repeat (3) @(negedge clk);
      check("reads_outstanding", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
